// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and helpers for the pipelined subtractor
package sub_pkg;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic bout;
    logic ovf;
  } sub_flags_t;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Built at MAX_W and sliced to WIDTH by the user.
  function automatic logic [MAX_W-1:0] sat_pos(input int width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_neg(input int width);
    return MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// rtl/sub_chunk.sv - combinational ripple-borrow subtractor for one chunk
module sub_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_c,
  input  logic [W-1:0] b_c,
  input  logic         br_in,
  output logic [W-1:0] d_c,
  output logic         br_out
);

  logic [W:0] br;

  always_comb begin
    br    = '0;
    d_c   = '0;
    br[0] = br_in;
    for (int i = 0; i < W; i++) begin
      d_c[i]   = a_c[i] ^ b_c[i] ^ br[i];
      br[i+1]  = (~a_c[i] & (b_c[i] ^ br[i])) | (b_c[i] & br[i]);
    end
  end

  assign br_out = br[W];

endmodule

// File: rtl/pipe_subtractor.sv
// rtl/pipe_subtractor.sv - pipelined a - b - bin with borrow-out and overflow
// Optional signed saturation of diff on overflow: define PIPE_SUBTRACTOR_SAT_EN.
module pipe_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_subtractor: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic              adv;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] br_q, br_src, bc;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  d_src [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [CHUNK-1:0]  dc [STAGES];
  sub_flags_t        flags;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];

  // Stage k works on whatever stage k-1 registered; stage 0 sees the ports.
  always_comb begin
    v_d      = '0;
    br_src   = '0;
    v_d[0]   = in_valid;
    br_src[0] = bin;
    a_src[0] = a;
    b_src[0] = b;
    d_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k]    = v_q[k-1];
      br_src[k] = br_q[k-1];
      a_src[k]  = a_q[k-1];
      b_src[k]  = b_q[k-1];
      d_src[k]  = d_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sub_chunk #(.W(CHUNK)) u_chunk (
      .a_c    (a_src[k][k*CHUNK +: CHUNK]),
      .b_c    (b_src[k][k*CHUNK +: CHUNK]),
      .br_in  (br_src[k]),
      .d_c    (dc[k]),
      .br_out (bc[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      d_d[k] = d_src[k];
      d_d[k][k*CHUNK +: CHUNK] = dc[k];
    end
  end

  // The pipe moves as a single unit: every stage loads or every stage holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      br_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else if (adv) begin
      v_q  <= v_d;
      br_q <= bc;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_src[k];
        b_q[k] <= b_src[k];
        d_q[k] <= d_d[k];
      end
    end
  end

  assign flags.bout = br_q[STAGES-1];
  assign flags.ovf  = (a_q[STAGES-1][WIDTH-1] != b_q[STAGES-1][WIDTH-1]) &
                      (d_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
  assign bout = flags.bout;
  assign ovf  = flags.ovf;

`ifdef PIPE_SUBTRACTOR_SAT_EN
  localparam logic [MAX_W-1:0] SAT_POS_W = sat_pos(WIDTH);
  localparam logic [MAX_W-1:0] SAT_NEG_W = sat_neg(WIDTH);

  assign diff = !flags.ovf ? d_q[STAGES-1] :
                a_q[STAGES-1][WIDTH-1] ? SAT_NEG_W[WIDTH-1:0] : SAT_POS_W[WIDTH-1:0];
`else
  assign diff = d_q[STAGES-1];
`endif

endmodule

// File: doc/pipe_subtractor.md
Name: pipe_subtractor

Overview:
- Parametrised, pipelined N-bit subtractor: computes diff = a - b - bin over WIDTH bits.
- The borrow ripples through STAGES registered chunks of CHUNK = WIDTH/STAGES bits each.
- Generalises the single-bit full subtractor into a multi-bit datapath unit with a valid/ready handshake, borrow-out and a signed-overflow flag.
- Sits between operand sources and the ALU result mux in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages; WIDTH % STAGES == 0 is required (elaboration-time check, $error on violation).

Ports:
- clk  input  1  single clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- diff  output  WIDTH  a - b - bin modulo 2^WIDTH.
- bout  output  1  borrow-out from the MSB; 1 when unsigned a < b + bin.
- ovf  output  1  two's-complement overflow of the signed subtraction.

Behaviour:
- Reset (async assert, sync release to the clk domain upstream): all stage valid bits, all data/borrow registers, out_valid, diff, bout and ovf go to 0. in_ready is combinational, so it is 1 while in reset-released idle.
- Reset asserted mid-operation: all in-flight transactions are discarded, with no partial output.
- Advance rule: adv = !out_valid | out_ready. in_ready = adv.
  - When adv = 1, every stage register loads from its predecessor.
  - When adv = 0, the whole pipe holds; diff/bout/ovf remain stable while out_valid = 1 and out_ready = 0.
- Transfer: an input transfer occurs on a cycle with in_valid & in_ready. Stage 0 valid loads in_valid & adv.
- Stage k (k = 0..STAGES-1):
  - Computes the chunk difference of bits [k*CHUNK +: CHUNK] using the borrow registered from stage k-1 (stage 0 uses bin).
  - Registers the chunk result, its borrow-out, and the skewed remaining operand bits.
  - Lower result chunks travel alongside in delay registers.
- Latency: an accepted transfer at edge t produces out_valid = 1 after edge t+STAGES-1, i.e. the result is visible in the cycle after STAGES edges with no stall. Throughput is 1 per cycle while out_ready = 1.
- Chunk arithmetic: {borrow, d} = {1'b0, a_c} - {1'b0, b_c} - borrow_in, in CHUNK+1 bits. Per bit, d_i = a_i ^ b_i ^ br_i, and br_{i+1} = (~a_i & (b_i ^ br_i)) | (b_i & br_i).
- bout is the final stage borrow.
- ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]). The a/b MSBs needed for this are carried down the pipe.
- Pipelining boundaries:
  - Pipe full with out_ready = 0: in_ready = 0, and in_valid is ignored.
  - Simultaneous output drain and input accept in the same cycle is legal.
  - Bubbles are not compressed: pipeline holds as a unit.
- STAGES = 1: purely registered single-stage, latency 1.

Optional Feature:
- Macro: PIPE_SUBTRACTOR_SAT_EN.
- Defined: diff is signed-saturated whenever ovf = 1.
  - a[MSB] = 0 gives the most-positive value, {1'b0,{WIDTH-1{1'b1}}}.
  - a[MSB] = 1 gives the most-negative value, {1'b1,{WIDTH-1{1'b0}}}.
  - ovf still reports overflow; bout is unaffected.
- Undefined: diff is always the wrapped modulo result. Saturation logic is absent.

Decomposition:
- Package sub_pkg holds:
  - localparam-style function chunk_w(WIDTH, STAGES).
  - Typedef sub_flags_t as a struct of {bout, ovf}.
  - Saturation constants built from WIDTH via functions.
- One natural sub-module: sub_chunk.
  - Purely combinational CHUNK-bit ripple-borrow subtractor.
  - Inputs a_c, b_c, br_in; outputs d_c, br_out.
  - Instantiated STAGES times inside a generate loop.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0x0005, b=0x0003, bin=0 -> after 4 edges diff=0x0002, bout=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x0100, b=0x0001 -> diff=0x00FF, checking the cross-chunk borrow.
- a=0x0010, b=0x000F, bin=1 -> diff=0x0000, bout=0.
- a=0x8000, b=0x0001 -> ovf=1, and:
  - without PIPE_SUBTRACTOR_SAT_EN: diff=0x7FFF.
  - with PIPE_SUBTRACTOR_SAT_EN: diff=0x8000.
- Back-pressure and throughput:
  - Stream 8 back-to-back operands.
  - Drop out_ready for 3 cycles once out_valid = 1 -> in_ready = 0 during the stall, outputs held stable, all 8 results emerge in order with none lost or duplicated.
- Reset mid-operation:
  - Assert rst asynchronously with 3 transactions in flight -> out_valid = 0 immediately, diff/bout/ovf = 0.
  - After release, the next accepted operand appears with latency 4 and no stale results.
